// File: rtl/decred_spi_host_bridge_if.sv
// Wishbone classic slave bus bundle between the management core and the SPI host bridge.
interface decred_spi_host_bridge_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/decred_spi_host_bridge.sv
// Wishbone-controlled, byte-wide mode-0 SPI master that drives the miner's host SPI port
// from the management core, with a programmable SCLK half-period divider.
module decred_spi_host_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n_i,
    decred_spi_host_bridge_if.slave       wb,
    output logic                          spi_sclk_o,
    output logic                          spi_mosi_o,
    output logic                          spi_scsn_o,
    input  logic                          spi_miso_i
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic               cs_q;
    logic [DIV_W-1:0]   clkdiv_q;
    logic [7:0]         rx_q, rx_d;
    logic               done_q;
    logic               ovr_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               byte_done;

    logic        adr_match, req, acc, commit, wr, rd;
    logic [1:0]  reg_sel;
    logic        busy, expire, tx_start, tx_ovr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:16], wb.wbs_adr_i[1:0]};

    // Access is acked one cycle after the request; side effects commit on the ack cycle
    // so a TXDATA write acked in cycle N starts the engine in cycle N+1.
    assign adr_match = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req       = wb.wbs_stb_i & wb.wbs_cyc_i & adr_match;
    assign acc       = req & ~ack_q;
    assign commit    = req & ack_q;
    assign wr        = commit & wb.wbs_we_i;
    assign rd        = commit & ~wb.wbs_we_i;
    assign reg_sel   = wb.wbs_adr_i[3:2];

    assign busy      = (state_q != ST_IDLE);
    assign expire    = (cnt_q == '0);
    assign tx_start  = wr & (reg_sel == REG_TXDATA) & wb.wbs_sel_i[0] & ~busy;
    assign tx_ovr    = wr & (reg_sel == REG_TXDATA) & wb.wbs_sel_i[0] & busy;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {16'h0000, clkdiv_q, 7'h00, cs_q};
            REG_RXDATA: rdata = {24'h000000, rx_q};
            REG_STATUS: rdata = {29'h0, ovr_q, done_q, busy};
            default:    rdata = '0;
        endcase
    end

    // Bus interface and firmware-visible control/status registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            cs_q     <= 1'b0;
            clkdiv_q <= DIV_RESET;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ack_q <= acc;
            dat_q <= (acc & ~wb.wbs_we_i) ? rdata : '0;
            if (wr && reg_sel == REG_CTRL) begin
                if (wb.wbs_sel_i[0]) cs_q     <= wb.wbs_dat_i[0];
                if (wb.wbs_sel_i[1]) clkdiv_q <= wb.wbs_dat_i[15:8];
            end
            if (byte_done)
                done_q <= 1'b1;
            else if (rd && reg_sel == REG_RXDATA)
                done_q <= 1'b0;
            if (tx_ovr)
                ovr_q <= 1'b1;
            else if (wr && reg_sel == REG_STATUS && wb.wbs_sel_i[0] && wb.wbs_dat_i[2])
                ovr_q <= 1'b0;
        end
    end

    // Engine state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Engine next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tx_start) state_d = ST_LOW;
            ST_LOW:  if (expire)   state_d = ST_HIGH;
            ST_HIGH: if (expire)   state_d = (bit_q == 3'd7) ? ST_IDLE : ST_LOW;
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine datapath next values: half-period counter, shift register, SCLK/MOSI.
    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_d      = rx_q;
        byte_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    div_d   = clkdiv_q;
                    cnt_d   = clkdiv_q;
                    shift_d = wb.wbs_dat_i[7:0];
                    mosi_d  = wb.wbs_dat_i[7];
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_LOW: begin
                if (expire) begin
                    sclk_d = 1'b1;
                    cnt_d  = div_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HIGH: begin
                if (expire) begin
                    shift_d = {shift_q[6:0], spi_miso_i};
                    sclk_d  = 1'b0;
                    cnt_d   = div_q;
                    if (bit_q == 3'd7) begin
                        rx_d      = {shift_q[6:0], spi_miso_i};
                        byte_done = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = shift_q[6];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rx_q    <= rx_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_scsn_o   = ~cs_q;

endmodule

// File: tb/tb_decred_spi_host_bridge.sv
// Directed bench for decred_spi_host_bridge: register access, loopback, divider, overrun,
// async reset mid-byte and address decode, checked against bench-computed expectations.
module tb_decred_spi_host_bridge;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_TX   = BASE + 32'h4;
    localparam logic [31:0] A_RX   = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decred_spi_host_bridge_if wb();
    logic sclk, mosi, scsn, miso;
    logic loop_mode = 1'b1;
    logic miso_drv  = 1'b0;
    assign miso = loop_mode ? mosi : miso_drv;

    decred_spi_host_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb),
        .spi_sclk_o (sclk),
        .spi_mosi_o (mosi),
        .spi_scsn_o (scsn),
        .spi_miso_i (miso)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd_q[$];
    logic        bit_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        int waited = 0;
        @(negedge clk);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        @(negedge clk);
        while (!wb.wbs_ack_o && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        chk("ack_seen", 32'(wb.wbs_ack_o), 32'd1);
        rdata = wb.wbs_dat_o;
        @(negedge clk);
        chk("ack_single", 32'(wb.wbs_ack_o), 32'd0);
        bus_idle();
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        wb_xfer(1'b1, adr, dat, sel, d);
    endtask

    task automatic wb_read_chk(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        rd_q.push_back(exp);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, d);
        chk(tag, d, rd_q.pop_front());
    endtask

    // Starts one byte and measures it cycle by cycle while BUSY is high.
    task automatic run_byte(input int div, input logic [7:0] tx, input logic [7:0] slave, input logic lp);
        int busy_n = 0, rises = 0, falls = 0, run = 0, bad_runs = 0;
        logic prev = 1'b0;
        for (int i = 7; i >= 0; i--) bit_q.push_back(tx[i]);
        loop_mode = lp;
        miso_drv  = slave[7];
        wb_write(A_TX, {24'h0, tx}, 4'b0001);
        while (dut.busy && busy_n < 5000) begin
            busy_n++;
            if (sclk !== prev) begin
                if (run != div + 1) bad_runs++;
                run = 0;
                if (sclk) begin
                    rises++;
                    if (bit_q.size() > 0) chk("mosi_bit", 32'(mosi), 32'(bit_q.pop_front()));
                end else begin
                    falls++;
                    if (falls < 8) miso_drv = slave[7 - falls];
                end
            end
            run++;
            prev = sclk;
            @(negedge clk);
        end
        if (run != div + 1) bad_runs++;
        chk("busy_cycles", 32'(busy_n), 32'(16 * (div + 1)));
        chk("sclk_rises", 32'(rises), 32'd8);
        chk("sclk_half_periods", 32'(bad_runs), 32'd0);
        bit_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, edges, n;
        logic prev;
        bus_idle();

        // Reset held while the bus is toggled.
        rst_n = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wb.wbs_stb_i = i[0];
            wb.wbs_cyc_i = 1'b1;
            wb.wbs_adr_i = A_CTRL;
            if (wb.wbs_ack_o) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        chk("rst_scsn", 32'(scsn), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_dat_o", wb.wbs_dat_o, 32'd0);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        wb_read_chk(A_CTRL, 32'h0000_0300, "ctrl_reset");
        wb_read_chk(A_STAT, 32'h0, "status_reset");

        // Loopback at CLKDIV=0.
        wb_write(A_CTRL, 32'h0000_0001, 4'b0011);
        chk("cs_asserted", 32'(scsn), 32'd0);
        run_byte(0, 8'hA5, 8'h00, 1'b1);
        wb_read_chk(A_STAT, 32'h2, "loop_status_done");
        wb_read_chk(A_RX, 32'hA5, "loop_rxdata");
        wb_read_chk(A_STAT, 32'h0, "loop_status_clear");

        // Divider 3 with a model slave returning 0xC3.
        wb_write(A_CTRL, 32'h0000_0301, 4'b0011);
        run_byte(3, 8'h3C, 8'hC3, 1'b0);
        wb_read_chk(A_RX, 32'hC3, "div_rxdata");
        wb_read_chk(A_STAT, 32'h0, "div_status_clear");

        // Overrun: second TXDATA write while busy is dropped.
        loop_mode = 1'b1;
        wb_write(A_TX, 32'h55, 4'b0001);
        wb_write(A_TX, 32'hAA, 4'b0001);
        wb_read_chk(A_STAT, 32'h5, "ovr_status_busy");
        n = 0;
        while (dut.busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("ovr_busy_fell", 32'(dut.busy), 32'd0);
        wb_read_chk(A_STAT, 32'h6, "ovr_status_done");
        wb_write(A_STAT, 32'h4, 4'b0001);
        wb_read_chk(A_STAT, 32'h2, "ovr_w1c");
        wb_read_chk(A_RX, 32'h55, "ovr_first_byte");
        wb_read_chk(A_STAT, 32'h0, "ovr_status_clear");

        // Async reset after three SCLK edges.
        wb_write(A_TX, 32'hFF, 4'b0001);
        edges = 0;
        n = 0;
        prev = sclk;
        while (edges < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (sclk !== prev) edges++;
            prev = sclk;
        end
        chk("mid_edges", 32'(edges), 32'd3);
        chk("mid_sclk_high", 32'(sclk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_mosi", 32'(mosi), 32'd0);
        chk("arst_scsn", 32'(scsn), 32'd1);
        chk("arst_busy", 32'(dut.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read_chk(A_RX, 32'h0, "arst_rxdata");
        wb_read_chk(A_STAT, 32'h0, "arst_status");
        wb_read_chk(A_CTRL, 32'h0000_0300, "arst_ctrl");

        // Address decode and byte-lane enables.
        @(negedge clk);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_adr_i = BASE + 32'h10;
        wb.wbs_sel_i = 4'hF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) acks++;
        end
        chk("decode_no_ack", 32'(acks), 32'd0);
        bus_idle();
        wb_write(A_CTRL, 32'h0000_0500, 4'b0010);
        wb_write(A_CTRL, 32'h0000_FF01, 4'b0001);
        wb_read_chk(A_CTRL, 32'h0000_0501, "sel_lane0_only");
        chk("sel_cs", 32'(scsn), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decred_spi_host_bridge.md
# decred_spi_host_bridge

Wishbone-slave SPI master that lets the Caravel management core drive the miner's host-side SPI (SCSN/SCLK/MOSI in, MISO out) without an external host. It sits directly upstream of `decred_top` in `user_project_wrapper`. Its outputs are muxed onto the miner's SPI host inputs (mux outside this block), and `decred_top`'s MISO output returns here. The block performs byte-wide, mode-0 transfers with a programmable SCLK divider and exposes status/data registers to firmware.

## Interface
- `BASE_ADDR`, 32'h3000_0000: Wishbone base; block decodes `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `DIV_RESET`, 8'd3: reset value of CTRL.CLKDIV.
- `wb_clk_i` input 1: sole clock.
- `wb_rst_n_i` input 1: reset, asynchronous assert, active-low (wrapper drives `~wb_rst_i`).
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1: Wishbone classic strobe/cycle/write.
- `wbs_sel_i` input 4: byte lanes; only lanes 0-1 are honoured.
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_dat_o` output 32: read data, valid while `wbs_ack_o`=1, else 0.
- `spi_sclk_o` output 1: SPI clock to miner SCLK_fromHost.
- `spi_mosi_o` output 1: to miner MOSI_fromHost.
- `spi_scsn_o` output 1: active-low chip select to miner SCSN_fromHost.
- `spi_miso_i` input 1: from miner MISO_toHost.

## Operation
- Registers (offset = `wbs_adr_i[3:2]`):
  - 0x0 CTRL RW: bit0 CS (`spi_scsn_o = ~CS`, combinational from reg). Bits[15:8] CLKDIV. Reset CS=0, CLKDIV=DIV_RESET.
  - 0x4 TXDATA W: bits[7:0]. Write when idle starts a byte transfer. Write when busy is dropped and sets STATUS.OVR. Reads return 0.
  - 0x8 RXDATA R: bits[7:0] = last received byte, reset 0. A read clears STATUS.DONE.
  - 0xC STATUS: bit0 BUSY (RO), bit1 DONE (sticky, set at byte end), bit2 OVR (sticky, write-1-to-clear). Other bits read 0.
- Writes honour `wbs_sel_i[0]` for bits[7:0] and `wbs_sel_i[1]` for bits[15:8].
- Engine FSM: IDLE -> LOW -> HIGH -> (LOW | IDLE).
  - Start: latch CLKDIV into half-period reload `div_q`. Load shift reg. `spi_mosi_o`=TX[7], `spi_sclk_o`=0, bit count=0, enter LOW.
  - Each half period lasts `div_q+1` cycles (8-bit down-counter).
  - LOW expiry: `spi_sclk_o`=1, go HIGH.
  - HIGH expiry:
    - Shift `spi_miso_i` into LSB (sampled on the last HIGH cycle). `spi_sclk_o`=0.
    - If bit count=7: RXDATA <= shifted byte, DONE=1, go IDLE.
    - Otherwise: bit count+1, `spi_mosi_o` = next bit MSB-first, go LOW.
  - BUSY = (state != IDLE).
  - `spi_mosi_o` holds its last value in IDLE.
- CTRL writes during BUSY take effect immediately on CS. CLKDIV changes apply from the next byte only.
- Simultaneous DONE set and RXDATA read in the same cycle: set wins (DONE=1).
- Simultaneous OVR set and W1C clear: set wins.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `spi_sclk_o`=0, `spi_mosi_o`=0, `spi_scsn_o`=1, FSM IDLE, STATUS=0.
- Reset asserted mid-transfer aborts at once to the reset values. No partial byte is written to RXDATA.
- Wishbone:
  - `wbs_ack_o` rises the cycle after `stb&cyc` with an address match and stays high exactly 1 cycle.
  - No ack back-to-back on a held strobe: ack is gated by `~wbs_ack_o`.
  - No ack for non-matching addresses.
- A TXDATA write is acked in cycle N. BUSY=1 and LOW begin in cycle N+1.
- Byte duration: 16*(CLKDIV+1) cycles from BUSY rise to BUSY fall. DONE is visible the same cycle BUSY falls.
- SCLK period: 2*(CLKDIV+1) cycles. CLKDIV=0 gives wb_clk/2.

## Test plan
- Reset: hold `wb_rst_n_i`=0 while toggling WB -> `spi_scsn_o`=1, `spi_sclk_o`=0, no ack. Then release and read CTRL -> 0x0000_0300.
- Loopback: tie `spi_miso_i`=`spi_mosi_o`, CS=1, CLKDIV=0. Write TXDATA=0xA5 -> 8 SCLK rising edges, BUSY high 16 cycles, RXDATA=0xA5, STATUS=0x2, then 0x0 after the RXDATA read.
- Divider: CLKDIV=3, TX=0x3C, model slave returns 0xC3 -> SCLK high/low each 4 cycles, BUSY for 64 cycles, MOSI bits 0,0,1,1,1,1,0,0 at rising edges, RXDATA=0xC3.
- Overrun: write TXDATA twice 2 cycles apart -> only the first byte shifted, STATUS=0x5 during the transfer. Write STATUS=0x4 -> OVR clears.
- Reset mid-byte: assert reset after 3 SCLK edges -> outputs return to reset values asynchronously, RXDATA=0.
- Bus decode: access at BASE_ADDR+0x10 -> no ack. Read CTRL with `wbs_sel_i`=4'b0001 write of 0xFF01 -> CLKDIV unchanged, CS=1.
